program_loader: RTL

Byte-stream program loader sitting directly upstream of the bytecode microprocessor. It accepts a program as a valid/ready byte stream and discards bytes until the start marker. It stores the marker and all following bytes into an internal program buffer up to and including the end marker. It then serves the buffer to the processor's instruction-fetch port, returning the end/halt byte for every address past the loaded program.

---
 rtl/program_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: captures a marker-delimited program from a valid/ready byte
// stream into a local buffer and serves it to the processor fetch port.
// Fetches outside the loaded program return END_BYTE, which halts the core.
module program_loader #(
   parameter int          DEPTH      = 256,
   parameter int          ADDR_W     = 8,
   parameter logic [7:0]  START_BYTE = 8'h7E,
   parameter logic [7:0]  END_BYTE   = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [7:0]        fetch_data,
   output logic              prog_ready,
   output logic [ADDR_W:0]   prog_len,
   output logic              busy,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [7:0]          fetch_data_q, fetch_data_d;
   logic                we;
   logic [ADDR_W-1:0]   wr_addr;
   logic                xfer;

   // Program buffer; deliberately not reset, prog_len masks stale content.
   logic [7:0] mem [DEPTH];

   assign in_ready   = ((state_q == S_WAIT_START) || (state_q == S_LOAD)) && !load_start;
   assign busy       = (state_q == S_WAIT_START) || (state_q == S_LOAD);
   assign prog_ready = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   assign prog_len   = len_q;
   assign fetch_data = fetch_data_q;
   assign xfer       = in_valid && in_ready;

   // Next-state, pointer, length and buffer write enable.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      we      = 1'b0;
      wr_addr = ptr_q;
      if (load_start) begin
         state_d = S_WAIT_START;
         ptr_d   = '0;
         len_d   = '0;
      end else begin
         case (state_q)
            S_WAIT_START: begin
               if (xfer && (in_byte == START_BYTE)) begin
                  we      = 1'b1;
                  wr_addr = '0;
                  ptr_d   = ADDR_W'(1);
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  we    = 1'b1;
                  ptr_d = ptr_q + ADDR_W'(1);
                  if (in_byte == END_BYTE) begin
                     len_d   = {1'b0, ptr_q} + (ADDR_W + 1)'(1);
                     state_d = S_DONE;
                  end else if (ptr_q == LAST_ADDR) begin
                     // Last slot filled without a terminator: never wrap.
                     len_d   = FULL_LEN;
                     state_d = S_ERROR;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Fetch read: only a completed program is visible, and only within its length.
   always_comb begin
      fetch_data_d = END_BYTE;
      if ((state_q == S_DONE) && ({1'b0, fetch_addr} < len_q))
         fetch_data_d = mem[fetch_addr];
   end

   // Control and fetch registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         len_q        <= '0;
         fetch_data_q <= END_BYTE;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         len_q        <= len_d;
         fetch_data_q <= fetch_data_d;
      end
   end

   // Buffer write on the same edge as the accepted transfer.
   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= in_byte;
   end

endmodule
